// File: rtl/hd63701_intc.sv
// HD63701 interrupt front-end: pin synchronisers, latched NMI edge, timer/SCI request merge.
// Optional pin glitch filter enabled by defining HD63701_PINFILT_EN.
module hd63701_intc #(
  parameter int FILT_LEN = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clkren,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       ocf,
  input  logic       eoci,
  input  logic       icf,
  input  logic       eici,
  input  logic       tof,
  input  logic       etoi,
  input  logic       sci_irq,
  input  logic       vack,
  input  logic [7:0] vnum,
  output logic       NMI,
  output logic       IRQ,
  output logic       IRQ2_TIM,
  output logic       IRQ2_SCI
);

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("hd63701_intc: FILT_LEN must be within 2..15");
  end

  logic nmi_s1_q, nmi_s1_d, nmi_s2_q, nmi_s2_d, nmi_s3_q, nmi_s3_d;
  logic irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d;
  logic vld1_q, vld1_d, vld2_q, vld2_d;
  logic arm_q, arm_d;
  logic nmi_pend_q, nmi_pend_d;
  logic irq_q, irq_d, tim_q, tim_d, sci_q, sci_d;
  logic nmi_lvl, irq_lvl, nmi_edge, nmi_ack;

`ifdef HD63701_PINFILT_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  logic       nmi_flt_q, nmi_flt_d, irq_flt_q, irq_flt_d;
  logic [3:0] nmi_cnt_q, nmi_cnt_d, irq_cnt_q, irq_cnt_d;

  // Returns {filtered value, counter}; the counter only runs while s2 disagrees.
  function automatic logic [4:0] filt_step(input logic s2, input logic flt,
                                           input logic [3:0] cnt);
    logic [4:0] r;
    r = {flt, 4'd0};
    if (s2 != flt) begin
      if (cnt == FILT_LAST) r = {s2, 4'd0};
      else                  r = {flt, cnt + 4'd1};
    end
    return r;
  endfunction

  assign nmi_lvl = nmi_flt_q;
  assign irq_lvl = irq_flt_q;
`else
  assign nmi_lvl = nmi_s2_q;
  assign irq_lvl = irq_s2_q;
`endif

  // Edges only count once the pin has genuinely been seen high after reset.
  assign nmi_edge = arm_q & nmi_s3_q & ~nmi_lvl;
  assign nmi_ack  = vack && (vnum == 8'hFC);

  always_comb begin
    nmi_s1_d   = nmi_s1_q;
    nmi_s2_d   = nmi_s2_q;
    nmi_s3_d   = nmi_s3_q;
    irq_s1_d   = irq_s1_q;
    irq_s2_d   = irq_s2_q;
    vld1_d     = vld1_q;
    vld2_d     = vld2_q;
    arm_d      = arm_q;
    nmi_pend_d = nmi_pend_q;
    irq_d      = irq_q;
    tim_d      = tim_q;
    sci_d      = sci_q;
`ifdef HD63701_PINFILT_EN
    {nmi_flt_d, nmi_cnt_d} = {nmi_flt_q, nmi_cnt_q};
    {irq_flt_d, irq_cnt_d} = {irq_flt_q, irq_cnt_q};
`endif
    if (clkren) begin
      nmi_s1_d   = nmi_n;
      nmi_s2_d   = nmi_s1_q;
      nmi_s3_d   = nmi_lvl;
      irq_s1_d   = irq_n;
      irq_s2_d   = irq_s1_q;
      vld1_d     = 1'b1;
      vld2_d     = vld1_q;
      arm_d      = arm_q | (vld2_q & nmi_s2_q & nmi_lvl);
      // A new edge beats a simultaneous ack so the second NMI is not lost.
      nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_ack);
      irq_d      = ~irq_lvl;
      tim_d      = (ocf & eoci) | (icf & eici) | (tof & etoi);
      sci_d      = sci_irq;
`ifdef HD63701_PINFILT_EN
      {nmi_flt_d, nmi_cnt_d} = filt_step(nmi_s2_q, nmi_flt_q, nmi_cnt_q);
      {irq_flt_d, irq_cnt_d} = filt_step(irq_s2_q, irq_flt_q, irq_cnt_q);
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nmi_s1_q   <= 1'b1;
      nmi_s2_q   <= 1'b1;
      nmi_s3_q   <= 1'b1;
      irq_s1_q   <= 1'b1;
      irq_s2_q   <= 1'b1;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      arm_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      tim_q      <= 1'b0;
      sci_q      <= 1'b0;
`ifdef HD63701_PINFILT_EN
      nmi_flt_q  <= 1'b1;
      nmi_cnt_q  <= 4'd0;
      irq_flt_q  <= 1'b1;
      irq_cnt_q  <= 4'd0;
`endif
    end else begin
      nmi_s1_q   <= nmi_s1_d;
      nmi_s2_q   <= nmi_s2_d;
      nmi_s3_q   <= nmi_s3_d;
      irq_s1_q   <= irq_s1_d;
      irq_s2_q   <= irq_s2_d;
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      arm_q      <= arm_d;
      nmi_pend_q <= nmi_pend_d;
      irq_q      <= irq_d;
      tim_q      <= tim_d;
      sci_q      <= sci_d;
`ifdef HD63701_PINFILT_EN
      nmi_flt_q  <= nmi_flt_d;
      nmi_cnt_q  <= nmi_cnt_d;
      irq_flt_q  <= irq_flt_d;
      irq_cnt_q  <= irq_cnt_d;
`endif
    end
  end

  assign NMI      = nmi_pend_q;
  assign IRQ      = irq_q;
  assign IRQ2_TIM = tim_q;
  assign IRQ2_SCI = sci_q;

endmodule

// File: tb/tb_hd63701_intc.sv
// Directed bench for hd63701_intc; latencies follow the pin filter when HD63701_PINFILT_EN is set.
module tb_hd63701_intc;

`ifdef HD63701_PINFILT_EN
  localparam int FL = 3;
`else
  localparam int FL = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST, clkren, nmi_n, irq_n;
  logic       ocf, eoci, icf, eici, tof, etoi, sci_irq, vack;
  logic [7:0] vnum;
  logic       NMI, IRQ, IRQ2_TIM, IRQ2_SCI;

  int n_vec = 0;
  int n_err = 0;

  hd63701_intc #(.FILT_LEN(3)) dut (
    .CLK(CLK), .RST(RST), .clkren(clkren), .nmi_n(nmi_n), .irq_n(irq_n),
    .ocf(ocf), .eoci(eoci), .icf(icf), .eici(eici), .tof(tof), .etoi(etoi),
    .sci_irq(sci_irq), .vack(vack), .vnum(vnum),
    .NMI(NMI), .IRQ(IRQ), .IRQ2_TIM(IRQ2_TIM), .IRQ2_SCI(IRQ2_SCI)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic ack(input logic [7:0] v);
    vack = 1'b1; vnum = v;
    step(1);
    vack = 1'b0; vnum = 8'h00;
  endtask

  initial begin
    int seen, first, cnt;
    RST = 1'b1; clkren = 1'b1; nmi_n = 1'b0; irq_n = 1'b1;
    ocf = 0; eoci = 0; icf = 0; eici = 0; tof = 0; etoi = 0;
    sci_irq = 0; vack = 0; vnum = 8'h00;
    step(2);
    check("reset_outs", int'({NMI, IRQ, IRQ2_TIM, IRQ2_SCI}), 0);
    RST = 1'b0;

    // NMI held low through reset release must not fire
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (NMI) seen++;
    end
    check("no_spurious_nmi", seen, 0);

    nmi_n = 1'b1; step(6 + FL);
    nmi_n = 1'b0; step(2 + FL);
    check("nmi_lat_early", int'(NMI), 0);
    step(1);
    check("nmi_lat", int'(NMI), 1);

    ack(8'hF8);
    check("ack_f8_keeps", int'(NMI), 1);
    ack(8'hFC);
    check("ack_fc_clears", int'(NMI), 0);

    // Pending NMI, then a fresh edge lands on the same edge as the FC ack
    nmi_n = 1'b1; step(4 + FL);
    nmi_n = 1'b0; step(3 + FL);
    check("nmi_again", int'(NMI), 1);
    nmi_n = 1'b1; step(4 + FL);
    nmi_n = 1'b0; step(2 + FL);
    ack(8'hFC);
    check("set_wins", int'(NMI), 1);
    clkren = 1'b0; vack = 1'b1; vnum = 8'hFC;
    step(3);
    check("vack_gated", int'(NMI), 1);
    clkren = 1'b1; step(1);
    vack = 1'b0; vnum = 8'h00;
    check("ack2_clears", int'(NMI), 0);

    // IRQ level: 5-cycle low pulse
    irq_n = 1'b0; first = 0; cnt = 0;
    for (int i = 1; i <= 14 + FL; i++) begin
      step(1);
      if (i == 5) irq_n = 1'b1;
      if (IRQ) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    check("irq_start", first, 3 + FL);
    check("irq_width", cnt, 5);

    ocf = 1; eoci = 0; step(1);
    check("tim_masked", int'(IRQ2_TIM), 0);
    eoci = 1; step(1);
    check("tim_ocf", int'(IRQ2_TIM), 1);
    tof = 1; etoi = 1; ocf = 0; step(1);
    check("tim_tof", int'(IRQ2_TIM), 1);
    etoi = 0; step(1);
    check("tim_drop", int'(IRQ2_TIM), 0);
    icf = 1; eici = 1; step(1);
    check("tim_icf", int'(IRQ2_TIM), 1);
    icf = 0; tof = 0; eoci = 0; eici = 0; step(1);
    check("tim_clear", int'(IRQ2_TIM), 0);

    check("sci_idle", int'(IRQ2_SCI), 0);
    sci_irq = 1; step(1);
    sci_irq = 0;
    check("sci_pulse", int'(IRQ2_SCI), 1);
    step(1);
    check("sci_pulse_end", int'(IRQ2_SCI), 0);

    // clkren 1-of-2: latency in enabled edges only
    nmi_n = 1'b1; step(10 + 2 * FL);
    nmi_n = 1'b0;
    for (int i = 0; i < 2 + FL; i++) begin
      clkren = 1'b0; step(1);
      clkren = 1'b1; step(1);
    end
    check("half_rate_early", int'(NMI), 0);
    clkren = 1'b0; step(1);
    check("half_rate_hold", int'(NMI), 0);
    clkren = 1'b1; step(1);
    check("half_rate_nmi", int'(NMI), 1);
    ack(8'hFC);
    check("half_rate_ack", int'(NMI), 0);

`ifdef HD63701_PINFILT_EN
    nmi_n = 1'b1; step(10);
    nmi_n = 1'b0; step(2);
    nmi_n = 1'b1; step(10);
    check("filt_short_pulse", int'(NMI), 0);
    nmi_n = 1'b0; step(4);
    nmi_n = 1'b1; step(1);
    check("filt_long_early", int'(NMI), 0);
    step(1);
    check("filt_long_nmi", int'(NMI), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hd63701_intc.md
Name: hd63701_intc

Overview:
- Interrupt front-end for the HD63701 core, directly upstream of the microcode sequencer.
- Synchronises the external NMI/IRQ pins and latches the NMI falling edge until its vector is fetched.
- Merges the timer and SCI peripheral flags into the four request lines (NMI, IRQ, IRQ2_TIM, IRQ2_SCI) the sequencer consumes.
- Does not apply the I-mask; the sequencer gates with inte.

Parameters:
- FILT_LEN, 3: consecutive stable samples required by the pin filter (used only with the optional feature); legal range 2..15.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- clkren  in  1  rising-phase clock enable; all state updates are qualified by it
- nmi_n  in  1  external NMI pin, async, active low
- irq_n  in  1  external IRQ1 pin, async, active low
- ocf, eoci  in  1,1  timer output-compare flag / enable
- icf, eici  in  1,1  timer input-capture flag / enable
- tof, etoi  in  1,1  timer overflow flag / enable
- sci_irq  in  1  SCI combined interrupt request (already enable-gated by SCI)
- vack  in  1  single-clkren pulse from sequencer: vector load in progress
- vnum  in  8  vector low byte being loaded (valid with vack)
- NMI  out  1  NMI pending to sequencer
- IRQ  out  1  external IRQ level to sequencer
- IRQ2_TIM  out  1  combined timer request
- IRQ2_SCI  out  1  SCI request

Behaviour:
- Reset (async, RST=1):
  - NMI, IRQ, IRQ2_TIM, IRQ2_SCI = 0.
  - Synchroniser and edge flops = 1 (pins read as inactive).
  - nmi_pend = 0.
  - No spurious NMI edge on reset release while nmi_n is low; a falling edge must be seen after reset.
- Synchroniser: two flops per pin (s1, s2), advanced on clkren.
- NMI edge detection:
  - A third flop s3 holds the previous s2.
  - Edge = s3 & ~s2.
  - Edge sets nmi_pend on the same clkren.
- NMI latency: pin low before clkren edge k → NMI=1 after clkren edge k+2, i.e. 3 enabled edges.
- NMI clear: nmi_pend clears on clkren when vack=1 and vnum==8'hFC.
  - vack with any other vnum leaves nmi_pend unchanged.
  - Simultaneous edge and clearing ack: set wins, so NMI stays 1 and the second NMI is not lost.
- Multiple NMI edges while pending are absorbed (single latch, no counter).
- IRQ:
  - Level-sensitive, not latched: IRQ = registered ~s2.
  - Latency is 3 enabled edges from pin.
  - Deasserts with the same latency when the pin rises.
- IRQ2_TIM: registered (ocf&eoci)|(icf&eici)|(tof&etoi); 1 enabled-edge latency. Clearing a flag or its enable drops the output on the next clkren.
- IRQ2_SCI: registered sci_irq; 1 enabled-edge latency.
- clkren=0: all state holds; outputs stable.
- vack is ignored when clkren=0.
- Outputs are pure flop outputs (no combinational path from inputs).

Optional Feature:
- Macro: HD63701_PINFILT_EN.
- Defined:
  - A filter on each of nmi_n and irq_n after s2: a 4-bit counter reloads on any change of s2 versus the filtered value.
  - The filtered value updates only after FILT_LEN consecutive equal s2 samples.
  - Edge detection and IRQ use the filtered value.
  - Added latency is FILT_LEN enabled edges.
  - Pulses shorter than FILT_LEN samples are discarded.
  - Filtered value resets to 1 and counters reset to 0.
- Not defined: the filter is absent, and latencies are exactly as stated above.

Test Plan:
- Reset with nmi_n=0 held through RST release, clkren=1 every cycle → NMI stays 0 for 20 cycles; then nmi_n 1→0 → NMI=1 on 3rd edge after the fall.
- NMI pending, then vack=1, vnum=8'hF8 → NMI stays 1; then vack=1, vnum=8'hFC → NMI=0 next cycle.
- New nmi_n falling edge detected on the same clkren as vack/vnum=8'hFC → NMI remains 1 after that edge; a second FC ack → NMI=0.
- irq_n low for 5 cycles, then high → IRQ=1 for exactly 5 cycles, starting 3 edges after the fall.
- ocf=1, eoci=0 → IRQ2_TIM=0; set eoci=1 → IRQ2_TIM=1 next edge. tof=1, etoi=1, ocf=0 → stays 1. sci_irq pulse of 1 cycle → IRQ2_SCI 1-cycle pulse delayed 1.
- With HD63701_PINFILT_EN, FILT_LEN=3: nmi_n low for 2 cycles → no NMI; low for 4 cycles → NMI=1 at 3+3 edges after the fall. clkren toggling 1-of-2 → all latencies counted in enabled edges only.
